// File: rtl/uart_lock_status_tx.sv
// Sends "<O|C>\r\n" in 8N1 after reset and after each lock state change; change coalesced into one pending flag.
// Latency: start bit 2 cycles after lock_open is captured; no backpressure, busy is status only.
module uart_lock_status_tx #(
    parameter int         CLK_FREQ    = 50000000,
    parameter int         BAUD        = 9600,
    parameter logic [7:0] CHAR_OPEN   = 8'h4F,
    parameter logic [7:0] CHAR_CLOSED = 8'h43
) (
    input  logic clk,
    input  logic rst,
    input  logic lock_open,
    output logic tx_pin,
    output logic busy
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_baud_cnt, w_baud_cnt_nxt;
    logic [2:0]    r_bit_idx, w_bit_idx_nxt;
    logic [1:0]    r_byte_idx, w_byte_idx_nxt;
    logic          r_pos_act, r_pos_ant;
    logic          r_pending, w_pending_nxt;
    logic          r_latched, w_latched_nxt;
    logic          r_tx, w_tx_nxt;
    logic          r_busy;
    logic          w_change, w_bit_end, w_take;
    logic [7:0]    w_byte;

    assign w_change  = r_pos_act ^ r_pos_ant;
    assign w_bit_end = (r_baud_cnt == BAUD_LAST);

    always_comb begin
        case (r_byte_idx)
            2'd0:    w_byte = r_latched ? CHAR_OPEN : CHAR_CLOSED;
            2'd1:    w_byte = 8'h0D;
            default: w_byte = 8'h0A;
        endcase
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_baud_cnt_nxt = r_baud_cnt;
        w_bit_idx_nxt  = r_bit_idx;
        w_byte_idx_nxt = r_byte_idx;
        w_tx_nxt       = r_tx;
        w_take         = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (r_pending) begin
                    w_take         = 1'b1;
                    w_state_nxt    = S_START;
                    w_baud_cnt_nxt = '0;
                    w_byte_idx_nxt = 2'd0;
                    w_tx_nxt       = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt    = S_DATA;
                    w_baud_cnt_nxt = '0;
                    w_bit_idx_nxt  = 3'd0;
                    w_tx_nxt       = w_byte[0];
                end else begin
                    w_baud_cnt_nxt = r_baud_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_baud_cnt_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_tx_nxt      = w_byte[r_bit_idx + 3'd1];
                    end
                end else begin
                    w_baud_cnt_nxt = r_baud_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_baud_cnt_nxt = '0;
                    if (r_byte_idx != 2'd2) begin
                        w_byte_idx_nxt = r_byte_idx + 2'd1;
                        w_state_nxt    = S_START;
                        w_tx_nxt       = 1'b0;
                    end else if (r_pending) begin
                        // Chain the follow-up message with no idle gap.
                        w_take         = 1'b1;
                        w_byte_idx_nxt = 2'd0;
                        w_state_nxt    = S_START;
                        w_tx_nxt       = 1'b0;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_tx_nxt    = 1'b1;
                    end
                end else begin
                    w_baud_cnt_nxt = r_baud_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
        w_latched_nxt = w_take ? r_pos_act : r_latched;
        // A change seen on the consuming edge keeps the flag set.
        w_pending_nxt = w_change | (r_pending & ~w_take);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_byte_idx <= 2'd0;
            r_pos_act  <= lock_open;
            r_pos_ant  <= lock_open;
            r_pending  <= 1'b1;
            r_latched  <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_cnt_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_byte_idx <= w_byte_idx_nxt;
            r_pos_act  <= lock_open;
            r_pos_ant  <= r_pos_act;
            r_pending  <= w_pending_nxt;
            r_latched  <= w_latched_nxt;
            r_tx       <= w_tx_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
        end
    end

    assign tx_pin = r_tx;
    assign busy   = r_busy;
endmodule

// File: tb/tb_uart_lock_status_tx.sv
// Bench for uart_lock_status_tx: scoreboard of expected bytes checked by a line-level 8N1 decoder.
module tb_uart_lock_status_tx;
    localparam int CPB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, lock_open = 1'b0;
    logic tx_pin, busy;
    logic rst_d = 1'b1, lock_d = 1'b0;
    logic tx_d, busy_d;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];

    uart_lock_status_tx #(.CLK_FREQ(400), .BAUD(100), .CHAR_OPEN(8'h4F), .CHAR_CLOSED(8'h43)) u_dut (
        .clk(clk), .rst(rst), .lock_open(lock_open), .tx_pin(tx_pin), .busy(busy)
    );

    uart_lock_status_tx u_dut_def (
        .clk(clk), .rst(rst_d), .lock_open(lock_d), .tx_pin(tx_d), .busy(busy_d)
    );

    // Line decoder: frame aligned on first low sample, every bit must hold CPB samples.
    int         m_cnt = 0;
    bit         m_active = 0;
    bit         m_bad = 0;
    logic       m_lv = 1'b1;
    logic [7:0] m_byte = 8'h00;
    logic [7:0] m_exp;
    always @(negedge clk) begin
        if (rst) begin
            m_active = 0;
        end else if (!m_active) begin
            if (tx_pin === 1'b0) begin
                m_active = 1; m_cnt = 0; m_lv = 1'b0; m_bad = 0;
            end
        end else begin
            m_cnt++;
            if (m_cnt % CPB == 0) m_lv = tx_pin;
            else if (tx_pin !== m_lv) m_bad = 1;
            if ((m_cnt % CPB == CPB/2) && m_cnt > CPB && m_cnt < 9*CPB)
                m_byte = {tx_pin, m_byte[7:1]};
            if (m_cnt == 10*CPB - 1) begin
                m_active = 0;
                n_tests++;
                if (m_bad || m_lv !== 1'b1) begin
                    n_fail++;
                    $display("FAIL frame_timing: byte %h glitch=%0d stop=%b, required stable bits and stop=1", m_byte, m_bad, m_lv);
                end
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_byte: got %h, required no byte", m_byte);
                end else begin
                    m_exp = exp_q.pop_front();
                    if (m_byte !== m_exp) begin
                        n_fail++;
                        $display("FAIL byte_value: got %h, required %h", m_byte, m_exp);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_msg(input logic [7:0] c);
        exp_q.push_back(c);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic wait_busy_rise(output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (busy === 1'b1) begin ok = 1; break; end
        end
    endtask

    task automatic count_busy(output int n);
        n = 1;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (busy !== 1'b1) break;
            n++;
        end
    endtask

    task automatic quiet_cycles(input int cyc, output int seen);
        seen = 0;
        for (int i = 0; i < cyc; i++) begin
            @(posedge clk); #1;
            if (busy !== 1'b0) seen++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; lock_open = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (tx_pin !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b, required 1", tx_pin); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    endtask

    task automatic test_boot_report();
        int n, seen;
        push_msg(8'h43);
        rst = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (tx_pin !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL boot_start: tx=%b busy=%b, required tx=0 busy=1", tx_pin, busy);
        end
        count_busy(n);
        n_tests++;
        if (n != 30*CPB) begin n_fail++; $display("FAIL boot_busy_len: got %0d, required %0d", n, 30*CPB); end
        quiet_cycles(20, seen);
        n_tests++;
        if (seen != 0 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL boot_done: busy cycles=%0d left=%0d, required 0 and 0", seen, exp_q.size());
        end
    endtask

    task automatic test_open_event();
        int n, seen;
        @(negedge clk);
        lock_open = 1'b1;
        push_msg(8'h4F);
        @(posedge clk); @(posedge clk); #1;
        n_tests++;
        if (tx_pin !== 1'b1) begin n_fail++; $display("FAIL open_early: got %b, required 1 at k+1", tx_pin); end
        @(posedge clk); #1;
        n_tests++;
        if (tx_pin !== 1'b0) begin n_fail++; $display("FAIL open_latency: got %b, required 0 at k+2", tx_pin); end
        count_busy(n);
        n_tests++;
        if (n != 30*CPB) begin n_fail++; $display("FAIL open_busy_len: got %0d, required %0d", n, 30*CPB); end
        quiet_cycles(20, seen);
        n_tests++;
        if (seen != 0 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL open_done: busy cycles=%0d left=%0d, required 0 and 0", seen, exp_q.size());
        end
    endtask

    task automatic test_coalesce();
        int n, seen;
        bit ok;
        @(negedge clk);
        lock_open = 1'b0;
        push_msg(8'h43);
        wait_busy_rise(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL coalesce_start: busy got 0, required 1"); end
        fork
            count_busy(n);
            begin
                repeat (10) @(negedge clk);
                lock_open = 1'b1;
                push_msg(8'h4F);
                repeat (10) @(negedge clk);
                lock_open = 1'b0;
                repeat (10) @(negedge clk);
                lock_open = 1'b1;
            end
        join
        n_tests++;
        if (n != 60*CPB) begin n_fail++; $display("FAIL coalesce_busy_len: got %0d, required %0d", n, 60*CPB); end
        quiet_cycles(30, seen);
        n_tests++;
        if (seen != 0 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL coalesce_done: busy cycles=%0d left=%0d, required 0 and 0", seen, exp_q.size());
        end
    endtask

    task automatic test_reset_midframe();
        int n, seen;
        bit ok;
        @(negedge clk);
        lock_open = 1'b0;
        exp_q.push_back(8'h43);
        wait_busy_rise(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL midrst_start: busy got 0, required 1"); end
        repeat (14*CPB + 1) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (tx_pin !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL midrst_edge: tx=%b busy=%b, required tx=1 busy=0", tx_pin, busy);
        end
        @(posedge clk); #1;
        n_tests++;
        if (tx_pin !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL midrst_hold: tx=%b busy=%b, required tx=1 busy=0", tx_pin, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        push_msg(8'h43);
        @(posedge clk); #1;
        n_tests++;
        if (tx_pin !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL midrst_reboot: tx=%b busy=%b, required tx=0 busy=1", tx_pin, busy);
        end
        count_busy(n);
        n_tests++;
        if (n != 30*CPB) begin n_fail++; $display("FAIL midrst_busy_len: got %0d, required %0d", n, 30*CPB); end
        quiet_cycles(20, seen);
        n_tests++;
        if (seen != 0 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL midrst_done: busy cycles=%0d left=%0d, required 0 and 0", seen, exp_q.size());
        end
    endtask

    task automatic test_simultaneous();
        int n, seen;
        bit ok;
        @(negedge clk);
        lock_open = 1'b1;
        push_msg(8'h4F);
        wait_busy_rise(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL simul_start: busy got 0, required 1"); end
        fork
            count_busy(n);
            begin
                repeat (20) @(posedge clk);
                @(negedge clk);
                lock_open = 1'b0;
                repeat (30*CPB - 22) @(posedge clk);
                @(negedge clk);
                // Captured one edge before the final stop bit ends.
                lock_open = 1'b1;
                push_msg(8'h4F);
                push_msg(8'h4F);
            end
        join
        n_tests++;
        if (n != 90*CPB) begin n_fail++; $display("FAIL simul_busy_len: got %0d, required %0d", n, 90*CPB); end
        quiet_cycles(30, seen);
        n_tests++;
        if (seen != 0 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL simul_done: busy cycles=%0d left=%0d, required 0 and 0", seen, exp_q.size());
        end
    endtask

    task automatic test_default_params();
        int n1, n2;
        @(negedge clk);
        rst_d = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (tx_d !== 1'b0 || busy_d !== 1'b1) begin
            n_fail++; $display("FAIL def_start: tx=%b busy=%b, required tx=0 busy=1", tx_d, busy_d);
        end
        n1 = 0;
        for (int i = 0; i < 6000; i++) begin
            @(posedge clk); #1; n1++;
            if (tx_d === 1'b1) break;
        end
        n_tests++;
        if (n1 != 5208) begin n_fail++; $display("FAIL def_bit_period: got %0d, required 5208", n1); end
        n2 = 0;
        for (int i = 0; i < 12000; i++) begin
            @(posedge clk); #1; n2++;
            if (tx_d === 1'b0) break;
        end
        n_tests++;
        if (n2 != 2*5208) begin n_fail++; $display("FAIL def_two_bits: got %0d, required %0d", n2, 2*5208); end
        rst_d = 1'b1;
    endtask

    initial begin
        test_reset();
        test_boot_report();
        test_open_event();
        test_coalesce();
        test_reset_midframe();
        test_simultaneous();
        test_default_params();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
